// File: rtl/array_reader.sv
// Array reader: reads len entries from start_addr through a 1-cycle-latency array port and
// streams {out_addr, out_data} over valid/ready. Optional macro: ARRAY_READER_SKIP_ZERO_EN.
module array_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] w_cur_nxt;
    logic [ADDR_W-1:0] r_remaining;
    logic [ADDR_W-1:0] w_rem_nxt;
    logic [ADDR_W-1:0] w_rem_init;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] w_oaddr_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_odata_nxt;
    logic              w_last;

    // Remaining count after the first entry; any len with the top bit set is clamped to a full sweep.
    assign w_rem_init = len[ADDR_W] ? '1 : (len[ADDR_W-1:0] - ADDR_ONE);
    assign w_last     = (r_remaining == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_addr  <= w_cur_nxt;
            r_remaining <= w_rem_nxt;
            r_out_addr  <= w_oaddr_nxt;
            r_out_data  <= w_odata_nxt;
        end
    end

    // Handshake: out_valid is high for the whole of OUT with out_data/out_addr frozen;
    // an entry transfers on the first clock edge that sees out_valid=1 and out_ready=1.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_addr;
        w_rem_nxt   = r_remaining;
        w_oaddr_nxt = r_out_addr;
        w_odata_nxt = r_out_data;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_cur_nxt   = start_addr;
                        w_rem_nxt   = w_rem_init;
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                w_odata_nxt = rd_data;
                w_oaddr_nxt = r_cur_addr;
                w_state_nxt = S_OUT;
`ifdef ARRAY_READER_SKIP_ZERO_EN
                // Zero entries are consumed from len but never reach the stream.
                if (rd_data == '0) begin
                    w_odata_nxt = r_out_data;
                    w_oaddr_nxt = r_out_addr;
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_cur_nxt   = r_cur_addr + ADDR_ONE;
                        w_rem_nxt   = r_remaining - ADDR_ONE;
                        w_state_nxt = S_RD;
                    end
                end
`endif
            end
            S_OUT: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_cur_nxt   = r_cur_addr + ADDR_ONE;
                        w_rem_nxt   = r_remaining - ADDR_ONE;
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_en     = (r_state == S_RD);
    assign rd_addr   = r_cur_addr;
    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_array_reader.sv
// Bench for array_reader: table of commands with hand-computed counts/latencies, plus
// sequences for stall, mid-command reset, start-while-busy and zero-entry handling.
module tb_array_reader;
  localparam int W = 16;

  typedef struct {
    logic [7:0] sa;
    logic [8:0] ln;
    logic [7:0] key;
    int         exp_n;
    int         exp_dly;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic [8:0] len = '0;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [7:0] out_addr;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;

  logic [7:0]   mem [256];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_log[$];
  int           act_cyc_log[$];
  logic [7:0]   rd_log[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int ov_cnt = 0;
  int b_act, b_done, b_rd, b_ov;

  array_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / array model / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // monitor: logs transfers, reads, done pulses and valid cycles
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        act_log.push_back({out_addr, out_data});
        act_cyc_log.push_back(cyc);
      end
      if (rd_en) rd_log.push_back(rd_addr);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid) ov_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [7:0] key);
    for (int i = 0; i < 256; i++)
      mem[i] = (key == 8'h00) ? 8'(i) : ((8'(i) ^ key) | 8'h01);
  endtask

  task automatic mark();
    b_act  = act_log.size();
    b_done = done_cnt;
    b_rd   = rd_log.size();
    b_ov   = ov_cnt;
  endtask

  task automatic build_exp(input logic [7:0] sa, input int nreads);
    logic [7:0] a;
    exp_q.delete();
    for (int k = 0; k < nreads; k++) begin
      a = 8'(sa + 8'(k));
`ifdef ARRAY_READER_SKIP_ZERO_EN
      if (mem[a] != 8'h00) exp_q.push_back({a, mem[a]});
`else
      exp_q.push_back({a, mem[a]});
`endif
    end
  endtask

  // driver: one-cycle start pulse, then scrambles the command inputs
  task automatic issue(input logic [7:0] sa, input logic [8:0] ln);
    @(posedge clk); #1;
    mark();
    start = 1'b1; start_addr = sa; len = ln; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    start_addr = 8'($urandom_range(0, 255));
    len = 9'($urandom_range(0, 511));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == b_done && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  // scoreboard
  task automatic check_result(input string name, input logic [7:0] sa, input int nreads,
                              input int dly, input bit timed);
    check({name, " xfers"}, act_log.size() - b_act, exp_q.size());
    for (int k = 0; k < exp_q.size() && (b_act + k) < act_log.size(); k++) begin
      check({name, " xfer"}, act_log[b_act + k], exp_q[k]);
      if (timed) check({name, " xfer cyc"}, act_cyc_log[b_act + k] - t0, 3 * (k + 1));
    end
    check({name, " reads"}, rd_log.size() - b_rd, nreads);
    for (int k = 0; k < nreads && (b_rd + k) < rd_log.size(); k++)
      check({name, " rd_addr"}, rd_log[b_rd + k], 8'(sa + 8'(k)));
    check({name, " done cnt"}, done_cnt - b_done, 1);
    if (dly >= 0) check({name, " done dly"}, done_cyc - t0, dly);
    check({name, " idle"}, busy, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   k;
    vecs[0] = '{sa: 8'h10, ln: 9'd3,   key: 8'h00, exp_n: 3,   exp_dly: 10};
    vecs[1] = '{sa: 8'hFE, ln: 9'd4,   key: 8'h5A, exp_n: 4,   exp_dly: 13};
    vecs[2] = '{sa: 8'h00, ln: 9'd0,   key: 8'h33, exp_n: 0,   exp_dly: 1};
    vecs[3] = '{sa: 8'h80, ln: 9'd1,   key: 8'hC3, exp_n: 1,   exp_dly: 4};
    vecs[4] = '{sa: 8'hFF, ln: 9'd2,   key: 8'h6E, exp_n: 2,   exp_dly: 7};
    vecs[5] = '{sa: 8'h05, ln: 9'd256, key: 8'hA5, exp_n: 256, exp_dly: 769};
    vecs[6] = '{sa: 8'h30, ln: 9'd300, key: 8'h11, exp_n: 256, exp_dly: 769};
    vecs[7] = '{sa: 8'h00, ln: 9'd511, key: 8'hF0, exp_n: 256, exp_dly: 769};

    fill_mem(8'h00);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset rd_en", rd_en, 0);
    check("reset rd_addr", rd_addr, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_addr", out_addr, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset state", dbg_state, 0);

    for (int v = 0; v < 8; v++) begin
      fill_mem(vecs[v].key);
      build_exp(vecs[v].sa, vecs[v].exp_n);
      issue(vecs[v].sa, vecs[v].ln);
      wait_done(800);
      check_result($sformatf("v%0d", v), vecs[v].sa, vecs[v].exp_n, vecs[v].exp_dly, 1'b1);
      check($sformatf("v%0d valid cycles", v), ov_cnt - b_ov, vecs[v].exp_n);
    end

    // stall: out_ready low for 5 cycles of the first OUT
    fill_mem(8'h3C);
    build_exp(8'h20, 2);
    out_ready = 1'b0;
    issue(8'h20, 9'd2);
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("stall valid up", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall valid held", out_valid, 1);
      check("stall data", out_data, exp_q[0][7:0]);
      check("stall addr", out_addr, 8'h20);
      check("stall rd_en", rd_en, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(50);
    check_result("stall", 8'h20, 2, 12, 1'b0);
    check("stall valid cycles", ov_cnt - b_ov, 7);

    // reset during OUT of entry 2 of len=8, with start asserted in the same cycle
    fill_mem(8'h99);
    issue(8'h50, 9'd8);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort pre valid", out_valid, 1);
    check("abort pre addr", out_addr, 8'h51);
    reset = 1'b1; start = 1'b1; start_addr = 8'h00; len = 9'd5;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("abort rd_en", rd_en, 0);
    check("abort rd_addr", rd_addr, 0);
    check("abort out_valid", out_valid, 0);
    check("abort out_data", out_data, 0);
    check("abort out_addr", out_addr, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("abort xfers", act_log.size() - b_act, 1);
    check("abort no done", done_cnt - b_done, 0);
    check("abort still idle", busy, 0);
    fill_mem(8'h42);
    build_exp(8'h60, 2);
    issue(8'h60, 9'd2);
    wait_done(50);
    check_result("post abort", 8'h60, 2, 7, 1'b1);

    // start while busy (mid-read and in FIN) is ignored
    fill_mem(8'h17);
    build_exp(8'h70, 3);
    issue(8'h70, 9'd3);
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b1; start_addr = 8'h00; len = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("busy start fin", done, 1);
    start = 1'b1; start_addr = 8'h08; len = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    check_result("busy start", 8'h70, 3, 10, 1'b1);

    // array {5,0,0,7}
    fill_mem(8'h01);
    mem[0] = 8'd5; mem[1] = 8'd0; mem[2] = 8'd0; mem[3] = 8'd7;
    build_exp(8'h00, 4);
    issue(8'h00, 9'd4);
    wait_done(50);
`ifdef ARRAY_READER_SKIP_ZERO_EN
    check("skip xfer count", act_log.size() - b_act, 2);
    check_result("skip", 8'h00, 4, 11, 1'b0);
`else
    check("skip xfer count", act_log.size() - b_act, 4);
    check_result("skip", 8'h00, 4, 13, 1'b1);
`endif

    // all-zero command
    mem[8'h40] = 8'd0; mem[8'h41] = 8'd0; mem[8'h42] = 8'd0;
    build_exp(8'h40, 3);
    issue(8'h40, 9'd3);
    wait_done(50);
`ifdef ARRAY_READER_SKIP_ZERO_EN
    check("zeros valid cycles", ov_cnt - b_ov, 0);
    check_result("zeros", 8'h40, 3, 7, 1'b0);
`else
    check("zeros valid cycles", ov_cnt - b_ov, 3);
    check_result("zeros", 8'h40, 3, 10, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
